fp_div_arb: RTL and testbench

FP_DIV_ARB -- requirements
Module: fp_div_arb

---
 rtl/fp_div_pkg.sv | 18 +
 rtl/fp_div.sv | 66 ++++++
 rtl/fp_div_arb.sv | 122 ++++++++++++
 tb/tb_fp_div_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types for the round-robin arbitrated single-precision divider.
package fp_div_pkg;

  localparam int unsigned FP_W = 32;

  typedef struct packed {
    logic exp_overflow;
    logic nan;
    logic zero;
  } fp_flags_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StResp
  } arb_state_t;

endpackage

// File: rtl/fp_div.sv
// Combinational IEEE-754 single-precision divider. Denormal inputs are flushed to zero and the
// quotient mantissa is truncated (round toward zero).
module fp_div
  import fp_div_pkg::*;
(
  input  logic [FP_W-1:0] opd1,
  input  logic [FP_W-1:0] opd2,
  output logic [FP_W-1:0] res,
  output logic            exp_overflow,
  output logic            nan,
  output logic            zero
);

  logic              sgn;
  logic [7:0]        e1, e2;
  logic [22:0]       f1, f2;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       num, den;
  logic [24:0]       q;
  logic signed [9:0] e_q;

  assign sgn = opd1[31] ^ opd2[31];
  assign e1  = opd1[30:23];
  assign e2  = opd2[30:23];
  assign f1  = opd1[22:0];
  assign f2  = opd2[22:0];

  assign a_zero = (e1 == 8'h00);
  assign b_zero = (e2 == 8'h00);
  assign a_inf  = (e1 == 8'hFF) && (f1 == '0);
  assign b_inf  = (e2 == 8'hFF) && (f2 == '0);
  assign a_nan  = (e1 == 8'hFF) && (f1 != '0);
  assign b_nan  = (e2 == 8'hFF) && (f2 != '0);

  // Mantissa ratio lies in (0.5, 2); q[24] set means the ratio is >= 1.
  assign num = {1'b1, f1, 24'b0};
  assign den = {24'b0, 1'b1, f2};
  assign q   = 25'(num / den);
  assign e_q = $signed({2'b00, e1}) - $signed({2'b00, e2}) + (q[24] ? 10'sd127 : 10'sd126);

  always_comb begin
    res          = '0;
    exp_overflow = 1'b0;
    nan          = 1'b0;
    zero         = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      nan = 1'b1;
      res = 32'h7FC0_0000;
    end else if (a_zero || b_inf) begin
      zero = 1'b1;
      res  = {sgn, 31'b0};
    end else if (b_zero || a_inf) begin
      exp_overflow = 1'b1;
      res          = {sgn, 8'hFF, 23'b0};
    end else if (e_q >= 10'sd255) begin
      exp_overflow = 1'b1;
      res          = {sgn, 8'hFF, 23'b0};
    end else if (e_q <= 10'sd0) begin
      zero = 1'b1;
      res  = {sgn, 31'b0};
    end else begin
      res = {sgn, e_q[7:0], (q[24] ? q[23:1] : q[22:0])};
    end
  end

endmodule

// File: rtl/fp_div_arb.sv
// NREQ requesters share one fp_div through a round-robin IDLE/CALC/RESP controller.
// Define FP_DIV_ARB_STATS_EN to build saturating per-requester completion counters.
module fp_div_arb
  import fp_div_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*FP_W-1:0]  req_opd1,
  input  logic [NREQ*FP_W-1:0]  req_opd2,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [FP_W-1:0]       rsp_res,
  output logic [2:0]            rsp_flags,
  output logic                  busy,
  output logic [NREQ*CNT_W-1:0] stat_cnt
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  arb_state_t       state_q;
  logic [PTR_W-1:0] ptr_q, owner_q, grant_idx, cand;
  logic             grant_any, accept, rsp_done;
  logic [FP_W-1:0]  opd1_q, opd2_q, res_q, div_res;
  fp_flags_t        flags_q;
  logic             div_ovf, div_nan, div_zero;
  logic [NREQ-1:0]  rsp_valid_q;

  // First valid requester at or after ptr_q, wrapping modulo NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PTR_W'((32'(ptr_q) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign req_ready = (!rst && state_q == StIdle && grant_any) ? (NREQ'(1) << grant_idx) : '0;
  assign accept    = |(req_valid & req_ready);
  assign rsp_done  = (state_q == StResp) && rsp_ready[owner_q];

  fp_div u_fp_div (
    .opd1         (opd1_q),
    .opd2         (opd2_q),
    .res          (div_res),
    .exp_overflow (div_ovf),
    .nan          (div_nan),
    .zero         (div_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      opd1_q      <= '0;
      opd2_q      <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            opd1_q  <= req_opd1[grant_idx*FP_W +: FP_W];
            opd2_q  <= req_opd2[grant_idx*FP_W +: FP_W];
            owner_q <= grant_idx;
            ptr_q   <= PTR_W'((32'(grant_idx) + 1) % NREQ);
            state_q <= StCalc;
          end
        end
        StCalc: begin
          res_q       <= div_res;
          flags_q     <= {div_ovf, div_nan, div_zero};
          rsp_valid_q <= NREQ'(1) << owner_q;
          state_q     <= StResp;
        end
        StResp: begin
          // Result registers are cleared so outputs read zero whenever nothing is valid.
          if (rsp_done) begin
            res_q       <= '0;
            flags_q     <= '0;
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;
  assign busy      = (state_q != StIdle);

`ifdef FP_DIV_ARB_STATS_EN
  logic [NREQ*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (rsp_done && (cnt_q[owner_q*CNT_W +: CNT_W] != '1)) begin
      cnt_q[owner_q*CNT_W +: CNT_W] <= cnt_q[owner_q*CNT_W +: CNT_W] + 1'b1;
    end
  end

  assign stat_cnt = cnt_q;
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_div_arb.sv
// Directed self-checking bench for fp_div_arb (NREQ=2, CNT_W=4).
module tb_fp_div_arb;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned CNT_W = 4;

`ifdef FP_DIV_ARB_STATS_EN
  localparam logic [31:0] EXP_SAT = 32'hF;
`else
  localparam logic [31:0] EXP_SAT = 32'h0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*32-1:0]    req_opd1;
  logic [NREQ*32-1:0]    req_opd2;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [31:0]           rsp_res;
  logic [2:0]            rsp_flags;
  logic                  busy;
  logic [NREQ*CNT_W-1:0] stat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_div_arb #(
    .NREQ  (NREQ),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opd1  (req_opd1),
    .req_opd2  (req_opd2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_flags (rsp_flags),
    .busy      (busy),
    .stat_cnt  (stat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One complete transaction with rsp_ready held high.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [2:0] ef, input string tag);
    int n;
    @(posedge clk);
    #1;
    req_valid               = '0;
    req_valid[idx]          = 1'b1;
    req_opd1[idx*32 +: 32]  = a;
    req_opd2[idx*32 +: 32]  = b;
    rsp_ready               = '1;
    n = 0;
    @(negedge clk);
    while (!req_ready[idx] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(1 << idx));
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check({tag, "_calc"}, 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(rsp_valid), 32'(1 << idx));
    check({tag, "_res"}, rsp_res, er);
    check({tag, "_flags"}, 32'(rsp_flags), 32'(ef));
    @(negedge clk);
    check({tag, "_cleared"}, rsp_res, 32'h0);
  endtask

  initial begin
    int          n;
    logic [1:0]  exp_g;
    logic [31:0] exp_r;

    rst       = 1'b1;
    req_valid = '1;
    req_opd1  = '0;
    req_opd2  = '0;
    rsp_ready = '0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stat", 32'(stat_cnt), 32'h0);
    check("rst_res", rsp_res, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;

    // Single op and flag vectors
    run_op(0, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, "div6_2");
    run_op(1, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 3'b001, "zero");
    run_op(0, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b010, "nan");
    run_op(1, 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 3'b100, "ovf");

    // Contention: both requesters valid continuously, grants alternate 0,1,0,1
    do_reset();
    req_opd1  = {32'h4080_0000, 32'h40C0_0000};
    req_opd2  = {32'h4000_0000, 32'h4000_0000};
    rsp_ready = '1;
    req_valid = '1;
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (g % 2 == 0) ? 32'h4040_0000 : 32'h4000_0000;
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("cont_grant", 32'(req_ready), 32'(exp_g));
      n = 0;
      @(negedge clk);
      while (rsp_valid == '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("cont_owner", 32'(rsp_valid), 32'(exp_g));
      check("cont_res", rsp_res, exp_r);
      check("cont_no_grant_in_resp", 32'(req_ready), 32'h0);
    end
    req_valid = '0;

    // Backpressure with a queued requester and a non-owner rsp_ready
    do_reset();
    req_valid = 2'b01;
    @(negedge clk);
    check("bp_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_res", rsp_res, 32'h4040_0000);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    check("bp_nonowner", 32'(rsp_valid), 32'h1);
    rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_done", 32'(rsp_valid), 32'h0);
    check("bp_next_grant", 32'(req_ready), 32'h2);
    req_valid = '0;
    @(negedge clk);
    check("bp_withdraw_idle", 32'(busy), 32'h0);
    req_valid = 2'b11;
    #1;
    check("bp_ptr_kept", 32'(req_ready), 32'h2);
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    check("bp_req1_valid", 32'(rsp_valid), 32'h2);
    check("bp_req1_res", rsp_res, 32'h4000_0000);
    req_valid = '0;

    // Reset while in CALC discards the operation and clears ptr
    @(posedge clk);
    #1 req_valid = 2'b10;
    @(negedge clk);
    check("mc_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("mc_busy_calc", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("mc_rst_valid", 32'(rsp_valid), 32'h0);
    check("mc_rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mc_no_rsp", 32'(rsp_valid), 32'h0);
    end
    check("mc_stat", 32'(stat_cnt), 32'h0);
    req_valid = 2'b11;
    #1;
    check("mc_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    #1;
    run_op(0, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, "mc_after");

    // Statistics saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      run_op(1, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, "stat_op");
    end
    check("stat_req1", 32'(stat_cnt[7:4]), EXP_SAT);
    check("stat_req0", 32'(stat_cnt[3:0]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
